banco_registros_param: RTL and testbench

//  Parametrised, clocked successor to the datapath register bank: 1 write port, 2 read ports.

---
 rtl/banco_pkg.sv | 20 ++
 rtl/banco_clr_fsm.sv | 95 +++++++++
 rtl/banco_registros_param.sv | 99 +++++++++
 tb/tb_banco_registros_param.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/banco_pkg.sv
// -----------------------------------------------------------------------------
// banco_pkg
// Shared definitions for the register bank and its neighbours (ALU, writeback
// mux). Holds the clear-engine state encoding and the default bank geometry.
// Optional feature macro used by the bank: BANCO_BYPASS_EN (write-through
// forwarding); it is handled in banco_registros_param, not here.
// -----------------------------------------------------------------------------
package banco_pkg;

  // Clear-engine states: idle, or walking the array zeroing one entry a cycle
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } estado_t;

  // Default geometry, shared with the ALU and the writeback mux
  localparam int BANCO_WIDTH = 32;
  localparam int BANCO_DEPTH = 32;

endpackage

// File: rtl/banco_clr_fsm.sv
// -----------------------------------------------------------------------------
// banco_clr_fsm
// Sequential bulk-clear engine for the register bank. After a clr_start pulse
// in IDLE it spends exactly DEPTH cycles in CLEAR, presenting one address per
// cycle to the array together with a clear strobe. It also flags writes that
// arrive while it is busy, since the array drops those writes.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   clr_start in   single-cycle pulse, start a clear (ignored while busy)
//   we        in   write enable from writeback, only used to detect drops
//   busy      out  high while in CLEAR
//   wr_err    out  registered one-cycle pulse per write dropped while busy
//   clr_we    out  clear strobe to the array
//   clr_addr  out  entry to clear this cycle
// Configuration macro: none (BANCO_BYPASS_EN is handled in the top).
// -----------------------------------------------------------------------------
module banco_clr_fsm
  import banco_pkg::*;
#(
  parameter int DEPTH = BANCO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_start,
  input  logic          we,
  output logic          busy,
  output logic          wr_err,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  estado_t       r_state;
  estado_t       w_stateNext;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cntNext;
  logic          r_wrErr;

  // State and counter registers; reset aborts any clear in progress at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  // Next-state logic. The counter is parked at 0 on leaving CLEAR so the
  // terminal compare against DEPTH-1 never lets it wrap.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    case (r_state)
      IDLE: begin
        if (clr_start) begin
          w_stateNext = CLEAR;
          w_cntNext   = '0;
        end
      end
      CLEAR: begin
        if (r_cnt == LAST_ADDR) begin
          w_stateNext = IDLE;
          w_cntNext   = '0;
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_cntNext   = '0;
      end
    endcase
  end

  // A write presented while busy is dropped by the array; flag it one cycle
  // later so writeback can see its result was lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrErr <= 1'b0;
    end else begin
      r_wrErr <= we && busy;
    end
  end

  assign busy     = (r_state == CLEAR);
  assign clr_we   = busy;
  assign clr_addr = r_cnt;
  assign wr_err   = r_wrErr;

endmodule

// File: rtl/banco_registros_param.sv
// -----------------------------------------------------------------------------
// banco_registros_param
// Parametrised register bank between decode (read addresses) and writeback
// (write port): one write port, two zero-latency read ports, optional
// hardwired-zero register 0, and a bulk-clear engine that zeroes the bank one
// entry per cycle.
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   we, wa, wd      write port, sampled at clk rise, dropped while busy
//   ra1/rd1, ra2/rd2 combinational read ports
//   clr_start       single-cycle pulse, start bulk clear
//   busy            high while the clear engine runs
//   wr_err          one-cycle pulse after a write was dropped during a clear
// Configuration macro: BANCO_BYPASS_EN -- when defined, an accepted write whose
// address matches a read address is forwarded to that read port in the same
// cycle; when undefined, reads show the old value until the write edge.
// -----------------------------------------------------------------------------
module banco_registros_param
  import banco_pkg::*;
#(
  parameter int  WIDTH   = BANCO_WIDTH,
  parameter int  DEPTH   = BANCO_DEPTH,
  localparam int AW      = $clog2(DEPTH),
  parameter int  R0_ZERO = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  input  logic             clr_start,
  output logic             busy,
  output logic             wr_err
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_busy;
  logic             w_clrWe;
  logic [AW-1:0]    w_clrAddr;
  logic             w_wrAccept;
  logic             w_r0Rd1;
  logic             w_r0Rd2;
  logic             w_fwd1;
  logic             w_fwd2;

  banco_clr_fsm #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clrFsm (
    .clk       (clk),
    .rst       (rst),
    .clr_start (clr_start),
    .we        (we),
    .busy      (w_busy),
    .wr_err    (wr_err),
    .clr_we    (w_clrWe),
    .clr_addr  (w_clrAddr)
  );

  // Writes to the hardwired-zero register are discarded silently, and all
  // writes are refused while the clear engine owns the array
  assign w_wrAccept = we && !w_busy && !((R0_ZERO != 0) && (wa == '0));

  // Storage array. The clear strobe and an accepted write are mutually
  // exclusive because writes are refused while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_clrWe) begin
      r_mem[w_clrAddr] <= '0;
    end else if (w_wrAccept) begin
      r_mem[wa] <= wd;
    end
  end

  assign w_r0Rd1 = (R0_ZERO != 0) && (ra1 == '0);
  assign w_r0Rd2 = (R0_ZERO != 0) && (ra2 == '0);

`ifdef BANCO_BYPASS_EN
  // Write-through: an accepted write is visible on a matching read port in the
  // same cycle (w_wrAccept already excludes the hardwired-zero case)
  assign w_fwd1 = w_wrAccept && (wa == ra1);
  assign w_fwd2 = w_wrAccept && (wa == ra2);
`else
  assign w_fwd1 = 1'b0;
  assign w_fwd2 = 1'b0;
`endif

  assign rd1  = w_r0Rd1 ? '0 : (w_fwd1 ? wd : r_mem[ra1]);
  assign rd2  = w_r0Rd2 ? '0 : (w_fwd2 ? wd : r_mem[ra2]);
  assign busy = w_busy;

endmodule

// File: tb/tb_banco_registros_param.sv
// -----------------------------------------------------------------------------
// tb_banco_registros_param
// Directed bench for banco_registros_param with the default geometry
// (WIDTH=32, DEPTH=32, R0_ZERO=1). Inputs change on the falling edge and
// outputs are sampled away from the rising edge. Honours BANCO_BYPASS_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_banco_registros_param;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic             clk;
  logic             rst;
  logic             we;
  logic [AW-1:0]    wa;
  logic [WIDTH-1:0] wd;
  logic [AW-1:0]    ra1;
  logic [AW-1:0]    ra2;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic             clrStart;
  logic             busy;
  logic             wrErr;

  int totalChecks = 0;
  int badChecks   = 0;
  int busyLen;

  banco_registros_param #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .R0_ZERO (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .ra1       (ra1),
    .ra2       (ra2),
    .rd1       (rd1),
    .rd2       (rd2),
    .clr_start (clrStart),
    .busy      (busy),
    .wr_err    (wrErr)
  );

  // 10 ns clock, active edge is the rising one
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison goes through here
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  // Present one write-port vector starting at the current falling edge
  task automatic applyStimulus(input logic wEn, input logic [AW-1:0] addr,
                               input logic [WIDTH-1:0] data);
    we = wEn;
    wa = addr;
    wd = data;
  endtask

  // Full write: drive at a falling edge, let the rising edge take it, release
  task automatic doWrite(input logic [AW-1:0] addr, input logic [WIDTH-1:0] data);
    applyStimulus(1'b1, addr, data);
    @(negedge clk);
    applyStimulus(1'b0, '0, '0);
  endtask

  // Guard against a hung run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    applyStimulus(1'b0, '0, '0);
    ra1 = '0;
    ra2 = '0;
    clrStart = 1'b0;

    // Asynchronous reset asserted mid-cycle, checked without any clock edge
    #3 rst = 1'b1;
    #1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_wrerr", 32'(wrErr), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      ra1 = AW'(i);
      ra2 = AW'(DEPTH - 1 - i);
      #0.1;
      checkOutput($sformatf("reset_rd1_%0d", i), rd1, 32'd0);
      checkOutput($sformatf("reset_rd2_%0d", i), rd2, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Plain write then read back; register 0 ignores writes without an error
    doWrite(5'd5, 32'hDEADBEEF);
    ra1 = 5'd5;
    #1 checkOutput("write_r5", rd1, 32'hDEADBEEF);
    doWrite(5'd0, 32'h00001234);
    ra1 = 5'd0;
    #1 checkOutput("write_r0_rd", rd1, 32'd0);
    checkOutput("write_r0_wrerr", 32'(wrErr), 32'd0);

    // Same-cycle write and read of register 7
    @(negedge clk);
    doWrite(5'd7, 32'h11111111);
    ra2 = 5'd7;
    applyStimulus(1'b1, 5'd7, 32'hA5A5A5A5);
    #1;
`ifdef BANCO_BYPASS_EN
    checkOutput("bypass_same_cycle", rd2, 32'hA5A5A5A5);
`else
    checkOutput("bypass_same_cycle", rd2, 32'h11111111);
`endif
    @(negedge clk);
    applyStimulus(1'b0, '0, '0);
    #1 checkOutput("bypass_after_edge", rd2, 32'hA5A5A5A5);

    // Fill the bank with 0x100+i
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      doWrite(AW'(i), 32'h100 + i);
    end
    ra1 = 5'd31;
    ra2 = 5'd1;
    #1 checkOutput("fill_r31", rd1, 32'h11F);
    checkOutput("fill_r1", rd2, 32'h101);

    // Bulk clear; busy rises the cycle after the pulse and lasts DEPTH cycles.
    // Along the way: a dropped write to r31, a clr_start that must be ignored,
    // and a mid-clear look at cleared and uncleared entries.
    @(negedge clk);
    clrStart = 1'b1;
    @(negedge clk);
    clrStart = 1'b0;
    busyLen = 0;
    while (busy && busyLen < 200) begin
      case (busyLen)
        5: applyStimulus(1'b1, 5'd31, 32'hDEAD0000);
        6: begin
          applyStimulus(1'b0, '0, '0);
          checkOutput("drop_wrerr_pulse", 32'(wrErr), 32'd1);
        end
        7: begin
          checkOutput("drop_wrerr_clear", 32'(wrErr), 32'd0);
          clrStart = 1'b1;
        end
        8: clrStart = 1'b0;
        10: begin
          ra1 = 5'd31;
          ra2 = 5'd3;
          #1;
          checkOutput("midclear_r31_old", rd1, 32'h11F);
          checkOutput("midclear_r3_zero", rd2, 32'd0);
        end
        default: ;
      endcase
      busyLen++;
      @(negedge clk);
    end
    checkOutput("busy_length", 32'(busyLen), 32'(DEPTH));
    checkOutput("after_clear_wrerr", 32'(wrErr), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      ra1 = AW'(i);
      #0.1 checkOutput($sformatf("after_clear_r%0d", i), rd1, 32'd0);
    end

    // Reset in the middle of a clear aborts it and zeroes the bank
    @(negedge clk);
    doWrite(5'd20, 32'h00002020);
    doWrite(5'd4, 32'h00000044);
    clrStart = 1'b1;
    @(negedge clk);
    clrStart = 1'b0;
    for (int n = 0; n < 10; n++) @(negedge clk);
    checkOutput("pre_rst_busy", 32'(busy), 32'd1);
    ra1 = 5'd20;
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_midclear_busy", 32'(busy), 32'd0);
    checkOutput("rst_midclear_r20", rd1, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    doWrite(5'd9, 32'h00000099);
    ra1 = 5'd9;
    #1 checkOutput("post_rst_write", rd1, 32'h99);
    checkOutput("post_rst_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
